reorder_buffer: RTL
===================

// Module: reorder_buffer
// PURPOSE
//  Circular in-order reorder buffer receiving the dual-issue allocation stream from the register alias table (register_file).
//  Takes completions from the ADD and MUL CDBs, retires the head in program order and drives the ROB broadcast bus the RAT listens on.
//  ROB entry index = rename tag; the next two free tags are offered to the dispatch units.
// PARAMETERS
//  DEPTH   8   entries; power of 2, >= 4
//  TAG_W   3   log2(DEPTH); tag width
//  DATA_W  32  result value width
//  REG_W   3   architectural register index width
// PORTS
//  clk                    in   1       sole clock, rising edge
//  reset                  in   1       synchronous, active-low (0 = reset)
//  RF_new_instr           in   1       RAT allocates two entries this cycle (instr a then b)
//  new_mul_a, new_mul_b   in   1       entry a/b is a multiply
//  rd_a, rd_b             in   REG_W   destination registers of a/b
//  alloc_tag_a            out  TAG_W   tag given to instr a (= tail)
//  alloc_tag_b            out  TAG_W   tag given to instr b (= tail+1 mod DEPTH)
//  rob_ready              out  1       >= 2 free entries; allocation accepted
//  add_cdb_valid          in   1       ADD unit result valid
//  add_cdb_tag            in   TAG_W   ADD result tag
//  add_cdb_value          in   DATA_W  ADD result value
//  mul_cdb_valid/tag/value             as ADD, for MUL unit
//  ROB_bus_trigger        out  1       one-cycle retire pulse
//  ROB_bus_tag            out  TAG_W   retired tag
//  ROB_bus_value          out  DATA_W  retired value
//  ROB_bus_rd             out  REG_W   retired destination register
//  rob_empty              out  1       count == 0
//  rob_error              out  1       sticky: overflow alloc or CDB to non-busy entry / CDB tag clash
// BEHAVIOUR
//  Entry fields: busy, done, is_mul, rd, value. head/tail TAG_W-bit, wrap mod DEPTH; count 0..DEPTH.
//  Reset (reset==0 at edge): head=tail=count=0; all busy/done=0; ROB_bus_* = 0; rob_error=0.
//   rob_ready forced 0 and rob_empty 1 while reset==0; alloc tags show 0 and 1.
//  rob_ready, alloc_tag_a/b, rob_empty combinational from registered state.
//  Allocate: RF_new_instr & rob_ready at edge -> entries tail, tail+1 set busy=1, done=0, rd, is_mul; tail += 2.
//   RF_new_instr with rob_ready==0: ignored, no state change, rob_error set.
//  Complete: CDB valid with busy & !done entry -> value captured, done=1 at that edge.
//   CDB to non-busy or already-done entry: ignored, rob_error set.
//   Both CDBs same tag same cycle: ADD accepted, MUL dropped, rob_error set.
//  Retire: at each edge, if head busy & done (registered state, no same-cycle CDB bypass):
//   ROB_bus_trigger<=1, tag/value/rd <= head entry, busy=done=0, head+=1; else ROB_bus_trigger<=0, other bus outputs hold.
//   Latency: CDB valid in cycle t -> ROB_bus_trigger high in cycle t+2 (head entry, no older pending).
//  Simultaneous alloc+retire: count <= count + 2 - retired; rob_ready evaluated from pre-edge count only.
//   Entry freed by retire this cycle is not reusable until next cycle.
//  Full (count==DEPTH) and count==DEPTH-1: rob_ready=0. Empty: no retire, trigger 0.
//  Tail/head wrap DEPTH-1 -> 0 with no gap; tail+1 wraps independently of tail.
//  Reset mid-operation: all in-flight entries discarded; a pending trigger pulse is cleared at the reset edge.
// CONFIGURATION
//  ROB_DUAL_COMMIT_EN defined: adds ROB_bus_trigger_b, ROB_bus_tag_b, ROB_bus_value_b, ROB_bus_rd_b (reset 0).
//   If head and head+1 both done, both retire at one edge (b = head+1); head += 2; count -= 2.
//   head+1 done, head not done: nothing retires.
//  Undefined: ports absent; at most one retirement per cycle.
// TESTING
//  Reset then reset=1 -> rob_ready=1, rob_empty=1, alloc tags 0/1, ROB_bus_trigger=0.
//  Alloc (rd 3,5) as tags 0,1; add_cdb tag1=77, then mul_cdb tag0=40 -> tag0 (rd3,40) retires, then tag1 (rd5,77) next cycle.
//  Four allocs, no CDB -> rob_ready=0 after 4th; 5th RF_new_instr ignored, rob_error=1, count stays 8.
//  Fill, retire 2, alloc 2 -> alloc tags 0,1 after wrap; retire order 2..7,0,1 preserved.
//  add_cdb and mul_cdb both tag 2 (values 9, 11) -> entry value 9, rob_error=1.
//  ROB_DUAL_COMMIT_EN: tags 0,1 done same cycle -> trigger and trigger_b pulse together with tags 0/1.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Interface between the RAT, the ADD/MUL CDBs and the reorder buffer.
// ROB_DUAL_COMMIT_EN adds the second retire bus.
interface reorder_buffer_if #(
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32,
  parameter int REG_W  = 3
);
  logic              RF_new_instr;
  logic              new_mul_a;
  logic              new_mul_b;
  logic [REG_W-1:0]  rd_a;
  logic [REG_W-1:0]  rd_b;
  logic [TAG_W-1:0]  alloc_tag_a;
  logic [TAG_W-1:0]  alloc_tag_b;
  logic              rob_ready;

  logic              add_cdb_valid;
  logic [TAG_W-1:0]  add_cdb_tag;
  logic [DATA_W-1:0] add_cdb_value;
  logic              mul_cdb_valid;
  logic [TAG_W-1:0]  mul_cdb_tag;
  logic [DATA_W-1:0] mul_cdb_value;

  logic              ROB_bus_trigger;
  logic [TAG_W-1:0]  ROB_bus_tag;
  logic [DATA_W-1:0] ROB_bus_value;
  logic [REG_W-1:0]  ROB_bus_rd;
  logic              rob_empty;
  logic              rob_error;
`ifdef ROB_DUAL_COMMIT_EN
  logic              ROB_bus_trigger_b;
  logic [TAG_W-1:0]  ROB_bus_tag_b;
  logic [DATA_W-1:0] ROB_bus_value_b;
  logic [REG_W-1:0]  ROB_bus_rd_b;
`endif

  modport master (
    output RF_new_instr, new_mul_a, new_mul_b, rd_a, rd_b,
    output add_cdb_valid, add_cdb_tag, add_cdb_value,
    output mul_cdb_valid, mul_cdb_tag, mul_cdb_value,
    input  alloc_tag_a, alloc_tag_b, rob_ready,
    input  ROB_bus_trigger, ROB_bus_tag, ROB_bus_value, ROB_bus_rd,
    input  rob_empty, rob_error
`ifdef ROB_DUAL_COMMIT_EN
    , input ROB_bus_trigger_b, ROB_bus_tag_b, ROB_bus_value_b, ROB_bus_rd_b
`endif
  );

  modport slave (
    input  RF_new_instr, new_mul_a, new_mul_b, rd_a, rd_b,
    input  add_cdb_valid, add_cdb_tag, add_cdb_value,
    input  mul_cdb_valid, mul_cdb_tag, mul_cdb_value,
    output alloc_tag_a, alloc_tag_b, rob_ready,
    output ROB_bus_trigger, ROB_bus_tag, ROB_bus_value, ROB_bus_rd,
    output rob_empty, rob_error
`ifdef ROB_DUAL_COMMIT_EN
    , output ROB_bus_trigger_b, ROB_bus_tag_b, ROB_bus_value_b, ROB_bus_rd_b
`endif
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: dual allocation, ADD/MUL CDB completion, in-order retire.
// Define ROB_DUAL_COMMIT_EN to retire up to two entries per cycle.
module reorder_buffer #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32,
  parameter int REG_W  = 3
) (
  input  logic            clk,
  input  logic            reset,
  reorder_buffer_if.slave rob_if
);
  localparam logic [TAG_W:0]   CNT_READY_MAX = (TAG_W+1)'(DEPTH - 2);
  localparam logic [TAG_W:0]   CNT_TWO       = (TAG_W+1)'(2);
  localparam logic [TAG_W-1:0] TAG_ONE       = TAG_W'(1);
  localparam logic [TAG_W-1:0] TAG_TWO       = TAG_W'(2);

  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [DEPTH-1:0]  is_mul_q, is_mul_d;
  logic [REG_W-1:0]  rd_q    [DEPTH];
  logic [REG_W-1:0]  rd_d    [DEPTH];
  logic [DATA_W-1:0] value_q [DEPTH];
  logic [DATA_W-1:0] value_d [DEPTH];
  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;
  logic              error_q, error_d;
  logic              trig_q, trig_d;
  logic [TAG_W-1:0]  bus_tag_q, bus_tag_d;
  logic [DATA_W-1:0] bus_value_q, bus_value_d;
  logic [REG_W-1:0]  bus_rd_q, bus_rd_d;
`ifdef ROB_DUAL_COMMIT_EN
  logic              trig_b_q, trig_b_d;
  logic [TAG_W-1:0]  bus_tag_b_q, bus_tag_b_d;
  logic [DATA_W-1:0] bus_value_b_q, bus_value_b_d;
  logic [REG_W-1:0]  bus_rd_b_q, bus_rd_b_d;
  logic [TAG_W-1:0]  head_p1;
`endif

  logic [TAG_W-1:0] tail_p1;
  logic             ready_int;
  logic             alloc_ok;
  logic             retire_a, retire_b;
  logic [1:0]       n_retire;
  logic             add_ok, mul_ok, mul_clash;

  assign tail_p1   = tail_q + TAG_ONE;
  assign ready_int = (count_q <= CNT_READY_MAX);
  assign alloc_ok  = rob_if.RF_new_instr & ready_int;

  // Retire decisions look only at registered done bits: no same-cycle CDB bypass.
  assign retire_a = busy_q[head_q] & done_q[head_q];
`ifdef ROB_DUAL_COMMIT_EN
  assign head_p1  = head_q + TAG_ONE;
  assign retire_b = retire_a & busy_q[head_p1] & done_q[head_p1];
`else
  assign retire_b = 1'b0;
`endif
  assign n_retire = {1'b0, retire_a} + {1'b0, retire_b};

  assign add_ok    = rob_if.add_cdb_valid & busy_q[rob_if.add_cdb_tag] & ~done_q[rob_if.add_cdb_tag];
  assign mul_clash = rob_if.add_cdb_valid & rob_if.mul_cdb_valid & (rob_if.add_cdb_tag == rob_if.mul_cdb_tag);
  assign mul_ok    = rob_if.mul_cdb_valid & ~mul_clash & busy_q[rob_if.mul_cdb_tag] & ~done_q[rob_if.mul_cdb_tag];

  assign rob_if.rob_ready       = reset & ready_int;
  assign rob_if.rob_empty       = ~reset | (count_q == '0);
  assign rob_if.alloc_tag_a     = reset ? tail_q  : '0;
  assign rob_if.alloc_tag_b     = reset ? tail_p1 : TAG_ONE;
  assign rob_if.rob_error       = error_q;
  assign rob_if.ROB_bus_trigger = trig_q;
  assign rob_if.ROB_bus_tag     = bus_tag_q;
  assign rob_if.ROB_bus_value   = bus_value_q;
  assign rob_if.ROB_bus_rd      = bus_rd_q;
`ifdef ROB_DUAL_COMMIT_EN
  assign rob_if.ROB_bus_trigger_b = trig_b_q;
  assign rob_if.ROB_bus_tag_b     = bus_tag_b_q;
  assign rob_if.ROB_bus_value_b   = bus_value_b_q;
  assign rob_if.ROB_bus_rd_b      = bus_rd_b_q;
`endif

  always_comb begin
    busy_d      = busy_q;
    done_d      = done_q;
    is_mul_d    = is_mul_q;
    rd_d        = rd_q;
    value_d     = value_q;
    error_d     = error_q;
    trig_d      = 1'b0;
    bus_tag_d   = bus_tag_q;
    bus_value_d = bus_value_q;
    bus_rd_d    = bus_rd_q;
`ifdef ROB_DUAL_COMMIT_EN
    trig_b_d      = 1'b0;
    bus_tag_b_d   = bus_tag_b_q;
    bus_value_b_d = bus_value_b_q;
    bus_rd_b_d    = bus_rd_b_q;
`endif

    if (retire_a) begin
      trig_d         = 1'b1;
      bus_tag_d      = head_q;
      bus_value_d    = value_q[head_q];
      bus_rd_d       = rd_q[head_q];
      busy_d[head_q] = 1'b0;
      done_d[head_q] = 1'b0;
    end
`ifdef ROB_DUAL_COMMIT_EN
    if (retire_b) begin
      trig_b_d        = 1'b1;
      bus_tag_b_d     = head_p1;
      bus_value_b_d   = value_q[head_p1];
      bus_rd_b_d      = rd_q[head_p1];
      busy_d[head_p1] = 1'b0;
      done_d[head_p1] = 1'b0;
    end
`endif

    // A retiring entry is already done, so it can never also be a legal CDB target.
    if (add_ok) begin
      value_d[rob_if.add_cdb_tag] = rob_if.add_cdb_value;
      done_d[rob_if.add_cdb_tag]  = 1'b1;
    end
    if (mul_ok) begin
      value_d[rob_if.mul_cdb_tag] = rob_if.mul_cdb_value;
      done_d[rob_if.mul_cdb_tag]  = 1'b1;
    end
    if ((rob_if.add_cdb_valid & ~add_ok) | (rob_if.mul_cdb_valid & ~mul_ok))
      error_d = 1'b1;

    if (alloc_ok) begin
      busy_d[tail_q]    = 1'b1;
      done_d[tail_q]    = 1'b0;
      rd_d[tail_q]      = rob_if.rd_a;
      is_mul_d[tail_q]  = rob_if.new_mul_a;
      busy_d[tail_p1]   = 1'b1;
      done_d[tail_p1]   = 1'b0;
      rd_d[tail_p1]     = rob_if.rd_b;
      is_mul_d[tail_p1] = rob_if.new_mul_b;
    end else if (rob_if.RF_new_instr) begin
      error_d = 1'b1;
    end

    head_d  = head_q + TAG_W'(n_retire);
    tail_d  = alloc_ok ? (tail_q + TAG_TWO) : tail_q;
    count_d = count_q + (alloc_ok ? CNT_TWO : '0) - (TAG_W+1)'(n_retire);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q      <= '0;
      done_q      <= '0;
      is_mul_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]    <= '0;
        value_q[i] <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      error_q     <= 1'b0;
      trig_q      <= 1'b0;
      bus_tag_q   <= '0;
      bus_value_q <= '0;
      bus_rd_q    <= '0;
`ifdef ROB_DUAL_COMMIT_EN
      trig_b_q      <= 1'b0;
      bus_tag_b_q   <= '0;
      bus_value_b_q <= '0;
      bus_rd_b_q    <= '0;
`endif
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      is_mul_q    <= is_mul_d;
      rd_q        <= rd_d;
      value_q     <= value_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      error_q     <= error_d;
      trig_q      <= trig_d;
      bus_tag_q   <= bus_tag_d;
      bus_value_q <= bus_value_d;
      bus_rd_q    <= bus_rd_d;
`ifdef ROB_DUAL_COMMIT_EN
      trig_b_q      <= trig_b_d;
      bus_tag_b_q   <= bus_tag_b_d;
      bus_value_b_q <= bus_value_b_d;
      bus_rd_b_q    <= bus_rd_b_d;
`endif
    end
  end
endmodule
